pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Game-sequencing controller for the Pong datapath. Owns the serve/play/point/game-over
//  state machine, keeps both scores, and gates the ball mover via a per-frame move enable,
//  a respawn pulse and a serve direction. Sits between the VGA scan counters, the ball
//  block's miss outputs and the score/overlay renderer; advances on end-of-frame ticks.
// PARAMETERS
//  SERVE_FRAMES  60   frames the ball is held at centre before each serve (1..255)
//  POINT_FRAMES  90   frames of freeze after a point before the next serve (1..255)
//  WIN_SCORE     7    score that ends the game (1..2**SCORE_W-1)
//  SCORE_W       4    width of each score counter
//  EOF_Y         481  scan line on which the end-of-frame tick fires (at x==0)
// PORTS
//  clk25M        in   1        25 MHz pixel clock; the only clock
//  reset_n       in   1        asynchronous, active-low reset
//  x, y          in   10 each  current VGA scan position
//  start         in   1        start/restart button, synchronous level
//  miss_l        in   1        ball passed left boundary (left player missed)
//  miss_r        in   1        ball passed right boundary (right player missed)
//  ball_move_en  out  1        one-cycle pulse: ball may step this frame
//  ball_respawn  out  1        one-cycle pulse: ball reloads centre position
//  serve_dir     out  1        1 = serve rightward, 0 = leftward
//  score_l       out  SCORE_W  left player score
//  score_r       out  SCORE_W  right player score
//  game_over     out  1        high while in OVER state
//  winner        out  1        0 = left won, 1 = right won; valid when game_over
//  state_o       out  3        current state encoding (debug/overlay)
// BEHAVIOUR
//  - frame_tick = (x==0 && y==EOF_Y); one clk25M cycle per frame. Frame counter (8 b)
//    counts frame_tick only. start edge-detected: registered, rise = start & ~start_q.
//  - States: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4 (3'd5-7 unused -> IDLE next cycle).
//  - Reset (async): state IDLE, scores 0, frame counter 0, serve_dir 1, winner 0,
//    ball_move_en 0, ball_respawn 0, game_over 0, start_q 0.
//  - IDLE: start rise -> SERVE; scores cleared, serve_dir 1.
//  - Entering SERVE: ball_respawn pulses 1 cycle (cycle after transition edge), counter 0.
//  - SERVE: counter increments on frame_tick; at SERVE_FRAMES ticks -> PLAY.
//  - PLAY: ball_move_en = frame_tick (combinational from registered state, same cycle).
//    Misses sampled only here; ignored in every other state.
//    miss_l only: score_r+1, serve_dir 0; miss_r only: score_l+1, serve_dir 1.
//    miss_l & miss_r same cycle: void rally, no score change, serve_dir unchanged.
//    Any miss -> POINT, counter 0. Scores update in the same edge as the transition.
//  - POINT: ball frozen; after POINT_FRAMES ticks -> OVER if either score == WIN_SCORE
//    (winner = 1 if score_r reached it), else SERVE.
//  - OVER: game_over=1, scores held; start rise -> IDLE-equivalent restart straight to
//    SERVE with scores cleared, serve_dir 1.
//  - Scores saturate at 2**SCORE_W-1; never wrap.
//  - start rise in SERVE/PLAY/POINT ignored. frame_tick and miss in same PLAY cycle:
//    move_en still pulses that cycle, transition to POINT at the edge.
//  - reset_n low mid-game aborts immediately; all outputs return to reset values.
// CONFIGURATION
//  PONG_PAUSE_EN: defined -> adds input pause (1 b, level) and state PAUSED=5. start rise
//  in SERVE/PLAY/POINT enters PAUSED (resume state saved, counter frozen, move_en 0,
//  misses ignored); next start rise returns to saved state, counter resumes. pause level
//  also forces PAUSED from those states. Undefined -> no pause port, start ignored as above,
//  state 5 unreachable.
// TESTING
//  1) reset_n low then high, no start -> IDLE, all outputs 0 except serve_dir=1 for 1000 frames.
//  2) start pulse -> respawn 1-cycle pulse, exactly 60 ticks later PLAY, move_en 1/frame only.
//  3) PLAY, miss_r pulse -> score_l=1, serve_dir=1, no move_en for 90 frames, respawn, SERVE.
//  4) miss_l & miss_r same cycle -> scores unchanged, POINT then SERVE.
//  5) drive miss_l 7 times -> score_r=7, after POINT game_over=1, winner=1; start -> scores 0, SERVE.
//  6) reset_n low mid-PLAY at score 3-2 -> immediately IDLE, scores 0; misses in IDLE ignored.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: serve/play/point/over sequencer and score keeper for the Pong datapath.
// Define PONG_PAUSE_EN to add the pause input and the PAUSED state.
module pong_game_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int EOF_Y        = 481
) (
  input  logic               clk25M,
  input  logic               reset_n,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               start,
  input  logic               miss_l,
  input  logic               miss_r,
`ifdef PONG_PAUSE_EN
  input  logic               pause,
`endif
  output logic               ball_move_en,
  output logic               ball_respawn,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state_o
);

  // state    | meaning
  // S_IDLE   | waiting for start, scores cleared on the way out
  // S_SERVE  | ball held at centre for SERVE_FRAMES frames
  // S_PLAY   | ball moving, misses scored
  // S_POINT  | freeze after a point for POINT_FRAMES frames
  // S_OVER   | game finished, winner valid
  // S_PAUSED | frozen, returns to saved state (PONG_PAUSE_EN only)
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_POINT  = 3'd3,
    S_OVER   = 3'd4,
    S_PAUSED = 3'd5
  } state_t;

  localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]         POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  state_t               r_state;
  logic [7:0]           r_cnt;
  logic [SCORE_W-1:0]   r_score_l;
  logic [SCORE_W-1:0]   r_score_r;
  logic                 r_serve_dir;
  logic                 r_winner;
  logic                 r_respawn;
  logic                 r_start_q;
`ifdef PONG_PAUSE_EN
  state_t               r_resume;
`endif

  logic w_frame_tick;
  logic w_start_rise;
  logic w_win_reached;

  assign w_frame_tick  = (x == 10'd0) && (y == 10'(EOF_Y));
  assign w_start_rise  = start & ~r_start_q;
  assign w_win_reached = (r_score_l == WIN) || (r_score_r == WIN);

  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_serve_dir <= 1'b1;
      r_winner    <= 1'b0;
      r_respawn   <= 1'b0;
      r_start_q   <= 1'b0;
`ifdef PONG_PAUSE_EN
      r_resume    <= S_IDLE;
`endif
    end else begin
      r_start_q <= start;
      r_respawn <= 1'b0;
`ifdef PONG_PAUSE_EN
      if ((r_state == S_SERVE || r_state == S_PLAY || r_state == S_POINT) &&
          (w_start_rise || pause)) begin
        r_resume <= r_state;
        r_state  <= S_PAUSED;
      end else
`endif
      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_start_rise) begin
            r_state     <= S_SERVE;
            r_cnt       <= 8'd0;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_serve_dir <= 1'b1;
            r_respawn   <= 1'b1;
          end
        end
        S_SERVE: begin
          if (w_frame_tick) begin
            if (r_cnt == SERVE_LAST) begin
              r_state <= S_PLAY;
              r_cnt   <= 8'd0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        S_PLAY: begin
          if (miss_l || miss_r) begin
            r_state <= S_POINT;
            r_cnt   <= 8'd0;
            // simultaneous misses void the rally
            if (miss_l && !miss_r) begin
              r_serve_dir <= 1'b0;
              if (r_score_r != SCORE_MAX) r_score_r <= r_score_r + SCORE_ONE;
            end else if (miss_r && !miss_l) begin
              r_serve_dir <= 1'b1;
              if (r_score_l != SCORE_MAX) r_score_l <= r_score_l + SCORE_ONE;
            end
          end
        end
        S_POINT: begin
          if (w_frame_tick) begin
            if (r_cnt == POINT_LAST) begin
              r_cnt <= 8'd0;
              if (w_win_reached) begin
                r_state  <= S_OVER;
                r_winner <= (r_score_r == WIN);
              end else begin
                r_state   <= S_SERVE;
                r_respawn <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
`ifdef PONG_PAUSE_EN
        S_PAUSED: begin
          if (w_start_rise && !pause) r_state <= r_resume;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ball_move_en = (r_state == S_PLAY) && w_frame_tick;
  assign ball_respawn = r_respawn;
  assign serve_dir    = r_serve_dir;
  assign score_l      = r_score_l;
  assign score_r      = r_score_r;
  assign game_over    = (r_state == S_OVER);
  assign winner       = r_winner;
  assign state_o      = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: randomized stimulus for pong_game_ctrl checked every cycle against a
// phase/score model, plus directed scenarios with literal expectations.
module tb_pong_game_ctrl;
  localparam int SERVE_N  = 60;
  localparam int POINT_N  = 90;
  localparam int WIN_N    = 7;
  localparam int EOF_LINE = 481;

  logic       clk25M  = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] x = 10'd5;
  logic [9:0] y = 10'd5;
  logic       start = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
  logic       ball_move_en, ball_respawn, serve_dir, game_over, winner;
  logic [3:0] score_l, score_r;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;
  int mv_cnt = 0;
  int rs_cnt = 0;
  bit cmp_en = 0;

  always #20 clk25M = ~clk25M;

  pong_game_ctrl dut (
    .clk25M(clk25M), .reset_n(reset_n), .x(x), .y(y), .start(start),
    .miss_l(miss_l), .miss_r(miss_r),
`ifdef PONG_PAUSE_EN
    .pause(1'b0),
`endif
    .ball_move_en(ball_move_en), .ball_respawn(ball_respawn), .serve_dir(serve_dir),
    .score_l(score_l), .score_r(score_r), .game_over(game_over), .winner(winner),
    .state_o(state_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game phase (0 idle,1 serve,2 play,3 point,4 over), ticks seen in phase.
  int m_phase = 0, m_ticks = 0, m_sl = 0, m_sr = 0;
  bit m_dir = 1, m_win = 0, m_respawn = 0, m_start_prev = 0;
  bit m_tick, m_rise;

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  always @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_ticks = 0; m_sl = 0; m_sr = 0;
      m_dir = 1; m_win = 0; m_respawn = 0; m_start_prev = 0;
    end else begin
      m_tick = (x == 0) && (y == EOF_LINE);
      m_rise = start && !m_start_prev;
      m_start_prev = start;
      m_respawn = 0;
      if (m_phase == 0 || m_phase == 4) begin
        if (m_rise) begin
          m_phase = 1; m_ticks = 0; m_sl = 0; m_sr = 0; m_dir = 1; m_respawn = 1;
        end
      end else if (m_phase == 1) begin
        if (m_tick) m_ticks++;
        if (m_ticks == SERVE_N) begin m_phase = 2; m_ticks = 0; end
      end else if (m_phase == 2) begin
        if (miss_l || miss_r) begin
          if (miss_l && !miss_r) begin m_sr = sat(m_sr + 1); m_dir = 0; end
          else if (miss_r && !miss_l) begin m_sl = sat(m_sl + 1); m_dir = 1; end
          m_phase = 3; m_ticks = 0;
        end
      end else if (m_phase == 3) begin
        if (m_tick) m_ticks++;
        if (m_ticks == POINT_N) begin
          m_ticks = 0;
          if (m_sl == WIN_N || m_sr == WIN_N) begin m_phase = 4; m_win = (m_sr == WIN_N); end
          else begin m_phase = 1; m_respawn = 1; end
        end
      end
    end
  end

  always @(negedge clk25M) begin
    #2;
    mv_cnt += int'(ball_move_en);
    rs_cnt += int'(ball_respawn);
    if (cmp_en) begin
      chk("state_o", 32'(state_o), m_phase);
      chk("score_l", 32'(score_l), m_sl);
      chk("score_r", 32'(score_r), m_sr);
      chk("serve_dir", 32'(serve_dir), 32'(m_dir));
      chk("ball_respawn", 32'(ball_respawn), 32'(m_respawn));
      chk("ball_move_en", 32'(ball_move_en), 32'(m_phase == 2 && x == 0 && y == EOF_LINE));
      chk("game_over", 32'(game_over), 32'(m_phase == 4));
      chk("winner", 32'(winner), 32'(m_win));
    end
  end

  task automatic cyc(input bit tk, input bit st, input bit ml, input bit mr);
    @(negedge clk25M);
    if (tk) begin
      x = 10'd0; y = 10'(EOF_LINE);
    end else begin
      x = 10'($urandom_range(0, 799));
      y = 10'($urandom_range(0, 524));
      if (x == 10'd0 && y == 10'(EOF_LINE)) y = 10'd480;
    end
    start = st; miss_l = ml; miss_r = mr;
    #1;
  endtask

  function automatic bit rb(input bit en);
    return en ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic frame(input int gap, input bit sn, input bit mn);
    cyc(1'b1, rb(sn), 1'b0, 1'b0);
    for (int i = 0; i < gap; i++) cyc(1'b0, rb(sn), rb(mn), rb(mn));
  endtask

  task automatic wait_state(input int st, input bit sn, output int n);
    n = 0;
    while (32'(state_o) != st && n < 400) begin
      frame($urandom_range(1, 3), sn, 1'b0);
      n++;
    end
    chk("wait_state", 32'(state_o), st);
  endtask

  task automatic point(input bit ml, input bit mr);
    int n;
    wait_state(2, 1'b1, n);
    frame($urandom_range(1, 3), 1'b1, 1'b0);
    cyc(1'b0, 1'b0, ml, mr);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    wait_state(1, 1'b1, n);
  endtask

  initial begin
    #3600000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, mv0, rs0, games;
    repeat (3) @(negedge clk25M);
    cmp_en = 1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_serve_dir", 32'(serve_dir), 1);
    chk("reset_state", 32'(state_o), 0);
    @(negedge clk25M); reset_n = 1'b1;

    // Idle for 1000 frames with stray misses: nothing moves
    mv0 = mv_cnt;
    repeat (1000) frame(1, 1'b0, 1'b1);
    chk("idle_state", 32'(state_o), 0);
    chk("idle_scores", 32'({score_l, score_r}), 0);
    chk("idle_serve_dir", 32'(serve_dir), 1);
    chk("idle_move_en", 32'(mv_cnt - mv0), 0);

    // Start: respawn pulse, then PLAY after exactly 60 frames
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("respawn_pulse", 32'(ball_respawn), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("respawn_end", 32'(ball_respawn), 0);
    wait_state(2, 1'b1, n);
    chk("serve_frames", n, 60);
    mv0 = mv_cnt;
    repeat (5) frame(2, 1'b1, 1'b0);
    chk("move_per_frame", 32'(mv_cnt - mv0), 5);

    // Right player misses: left scores, 90 frozen frames, respawn, SERVE
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("miss_r_score_l", 32'(score_l), 1);
    chk("miss_r_dir", 32'(serve_dir), 1);
    chk("miss_r_point", 32'(state_o), 3);
    mv0 = mv_cnt; rs0 = rs_cnt;
    wait_state(1, 1'b1, n);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("point_frames", n, 90);
    chk("point_no_move", 32'(mv_cnt - mv0), 0);
    chk("point_respawn", 32'(rs_cnt - rs0), 1);

    // Both miss on a frame tick: move still pulses, rally void
    wait_state(2, 1'b1, n);
    frame(2, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("tick_miss_move", 32'(ball_move_en), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("void_state", 32'(state_o), 3);
    chk("void_scores", 32'({score_l, score_r}), 32'h10);
    wait_state(1, 1'b1, n);

    // Left misses seven times: right wins
    for (int i = 0; i < 7; i++) begin
      wait_state(2, 1'b1, n);
      frame($urandom_range(1, 3), 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("miss_l_score_r", 32'(score_r), i + 1);
      chk("miss_l_dir", 32'(serve_dir), 0);
      wait_state((i < 6) ? 1 : 4, 1'b0, n);
    end
    repeat (10) frame(2, 1'b0, 1'b1);
    chk("over_flag", 32'(game_over), 1);
    chk("over_winner", 32'(winner), 1);
    chk("over_score_r", 32'(score_r), 7);
    chk("over_score_l", 32'(score_l), 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart_state", 32'(state_o), 1);
    chk("restart_scores", 32'({score_l, score_r}), 0);
    chk("restart_dir", 32'(serve_dir), 1);

    // Reach 3-2 then reset mid-PLAY
    point(1'b0, 1'b1); point(1'b1, 1'b0); point(1'b0, 1'b1);
    point(1'b1, 1'b0); point(1'b0, 1'b1);
    chk("score_3_2", 32'({score_l, score_r}), 32'h32);
    wait_state(2, 1'b1, n);
    frame(1, 1'b0, 1'b0);
    @(negedge clk25M); reset_n = 1'b0; #1;
    chk("abort_state", 32'(state_o), 0);
    chk("abort_scores", 32'({score_l, score_r}), 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk25M); reset_n = 1'b1;
    repeat (20) frame(1, 1'b0, 1'b1);
    chk("idle_miss_scores", 32'({score_l, score_r}), 0);

    // Randomized games
    games = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int it = 0; it < 8000 && games < 2; it++) begin
      if (state_o == 3'd4) begin
        games++;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
      end else if (state_o == 3'd2 && $urandom_range(0, 7) == 0) begin
        n = $urandom_range(1, 3);
        cyc(1'($urandom_range(0, 1)), 1'b0, n[1], n[0]);
      end else begin
        frame($urandom_range(1, 3), state_o != 3'd0, state_o != 3'd2);
      end
    end
    chk("random_games", games, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
